// File: rtl/updi_burst_gen.sv
// UPDI burst generator: one read/write command becomes SYNCH, ST ptr, address, optional REPEAT, ST/LD *(ptr++) frames.
// Frame appears the cycle after the triggering edge; the single frame register advances only when the TX shifter takes it.
module updi_burst_gen #(
    parameter int ADDR_BYTES = 2,
    parameter int STOP_BITS  = 2,
    parameter int PARITY_ODD = 0,
    localparam int FRAME_W   = 10 + STOP_BITS
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic                      i_cmd_valid,
    output logic                      o_cmd_ready,
    input  logic                      i_cmd_write,
    input  logic [8*ADDR_BYTES-1:0]   i_cmd_addr,
    input  logic [7:0]                i_cmd_len,
    input  logic [7:0]                i_wdata,
    input  logic                      i_wdata_valid,
    output logic                      o_wdata_ready,
    output logic [FRAME_W-1:0]        o_frame,
    output logic                      o_frame_valid,
    input  logic                      i_frame_ready,
    output logic                      o_tx_en,
    output logic                      o_rx_en,
    output logic [8:0]                o_rx_count,
    input  logic                      i_rx_done,
    input  logic                      i_abort,
    output logic                      o_done
);

    localparam int AW = 8 * ADDR_BYTES;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_SYNC0   = 4'd1;
    localparam logic [3:0] S_PTR_OP  = 4'd2;
    localparam logic [3:0] S_ADDR    = 4'd3;
    localparam logic [3:0] S_SYNC1   = 4'd4;
    localparam logic [3:0] S_RPT_OP  = 4'd5;
    localparam logic [3:0] S_RPT_CNT = 4'd6;
    localparam logic [3:0] S_SYNC2   = 4'd7;
    localparam logic [3:0] S_DATA_OP = 4'd8;
    localparam logic [3:0] S_WDATA   = 4'd9;
    localparam logic [3:0] S_RX_WAIT = 4'd10;

    localparam logic [7:0] SYNC_BYTE = 8'h55;
    localparam logic [7:0] PTR_BYTE  = 8'h68 | 8'(ADDR_BYTES - 1);
    localparam logic [7:0] RPT_BYTE  = 8'hA0;
    localparam logic [7:0] ST_INC    = 8'h64;
    localparam logic [7:0] LD_INC    = 8'h24;
    localparam logic [1:0] LAST_IDX  = 2'(ADDR_BYTES - 1);

    logic [3:0]         state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               frame_vld_q, frame_vld_d;
    logic               tx_en_q, tx_en_d;
    logic               rx_en_q, rx_en_d;
    logic               done_q, done_d;
    logic               cmd_rdy_q, cmd_rdy_d;
    logic               write_q, write_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [7:0]         len_q, len_d;
    logic [1:0]         idx_q, idx_d;
    logic [8:0]         cnt_q, cnt_d;
    logic [8:0]         rx_count_q, rx_count_d;

    logic       acc;
    logic       wdata_rdy;
    logic       wdata_take;
    logic [8:0] n_bytes;
    logic [7:0] data_op;

    function automatic logic [FRAME_W-1:0] mk_frame(input logic [7:0] b);
        logic par;
        par = (^b) ^ 1'(PARITY_ODD);
        return {1'b0, b, par, {STOP_BITS{1'b1}}};
    endfunction

    assign acc     = frame_vld_q & i_frame_ready;
    assign n_bytes = {1'b0, len_q} + 9'd1;
    assign data_op = write_q ? ST_INC : LD_INC;

    // The first payload byte may load on the same edge the ST opcode leaves, so writes run without a bubble.
    assign wdata_rdy  = ((state_q == S_WDATA) | ((state_q == S_DATA_OP) & write_q))
                        & (~frame_vld_q | i_frame_ready) & (cnt_q <= {1'b0, len_q});
    assign wdata_take = wdata_rdy & i_wdata_valid;

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        frame_vld_d = frame_vld_q;
        tx_en_d     = tx_en_q;
        rx_en_d     = rx_en_q;
        done_d      = 1'b0;
        write_d     = write_q;
        addr_d      = addr_q;
        len_d       = len_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        rx_count_d  = rx_count_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_rdy_q && i_cmd_valid) begin
                    write_d     = i_cmd_write;
                    addr_d      = i_cmd_addr;
                    len_d       = i_cmd_len;
                    rx_count_d  = {1'b0, i_cmd_len} + 9'd1;
                    cnt_d       = 9'd0;
                    idx_d       = 2'd0;
                    frame_d     = mk_frame(SYNC_BYTE);
                    frame_vld_d = 1'b1;
                    tx_en_d     = 1'b1;
                    state_d     = S_SYNC0;
                end
            end
            S_SYNC0: begin
                if (acc) begin
                    frame_d = mk_frame(PTR_BYTE);
                    state_d = S_PTR_OP;
                end
            end
            S_PTR_OP: begin
                if (acc) begin
                    frame_d = mk_frame(addr_q[7:0]);
                    addr_d  = addr_q >> 8;
                    idx_d   = 2'd0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (acc) begin
                    if (idx_q == LAST_IDX) begin
                        frame_d = mk_frame(SYNC_BYTE);
                        state_d = S_SYNC1;
                    end else begin
                        frame_d = mk_frame(addr_q[7:0]);
                        addr_d  = addr_q >> 8;
                        idx_d   = idx_q + 2'd1;
                    end
                end
            end
            S_SYNC1: begin
                if (acc) begin
                    if (len_q != 8'd0) begin
                        frame_d = mk_frame(RPT_BYTE);
                        state_d = S_RPT_OP;
                    end else begin
                        frame_d = mk_frame(data_op);
                        state_d = S_DATA_OP;
                    end
                end
            end
            S_RPT_OP: begin
                if (acc) begin
                    frame_d = mk_frame(len_q);
                    state_d = S_RPT_CNT;
                end
            end
            S_RPT_CNT: begin
                if (acc) begin
                    frame_d = mk_frame(SYNC_BYTE);
                    state_d = S_SYNC2;
                end
            end
            S_SYNC2: begin
                if (acc) begin
                    frame_d = mk_frame(data_op);
                    state_d = S_DATA_OP;
                end
            end
            S_DATA_OP: begin
                if (acc) begin
                    if (write_q) begin
                        state_d = S_WDATA;
                        if (wdata_take) begin
                            frame_d = mk_frame(i_wdata);
                            cnt_d   = cnt_q + 9'd1;
                        end else begin
                            frame_vld_d = 1'b0;
                        end
                    end else begin
                        frame_vld_d = 1'b0;
                        tx_en_d     = 1'b0;
                        rx_en_d     = 1'b1;
                        state_d     = S_RX_WAIT;
                    end
                end
            end
            S_WDATA: begin
                if (acc && (cnt_q == n_bytes)) begin
                    frame_vld_d = 1'b0;
                    tx_en_d     = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end else if (wdata_take) begin
                    frame_d     = mk_frame(i_wdata);
                    frame_vld_d = 1'b1;
                    cnt_d       = cnt_q + 9'd1;
                end else if (acc) begin
                    frame_vld_d = 1'b0;
                end
            end
            S_RX_WAIT: begin
                if (i_rx_done) begin
                    rx_en_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                frame_vld_d = 1'b0;
                tx_en_d     = 1'b0;
                rx_en_d     = 1'b0;
                state_d     = S_IDLE;
            end
        endcase

        // Abort wins over any accept or rx_done arriving in the same cycle.
        if ((state_q != S_IDLE) && i_abort) begin
            state_d     = S_IDLE;
            frame_vld_d = 1'b0;
            tx_en_d     = 1'b0;
            rx_en_d     = 1'b0;
            done_d      = 1'b0;
        end

        cmd_rdy_d = (state_d == S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= S_IDLE;
            frame_q     <= '0;
            frame_vld_q <= 1'b0;
            tx_en_q     <= 1'b0;
            rx_en_q     <= 1'b0;
            done_q      <= 1'b0;
            cmd_rdy_q   <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            len_q       <= 8'd0;
            idx_q       <= 2'd0;
            cnt_q       <= 9'd0;
            rx_count_q  <= 9'd0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            frame_vld_q <= frame_vld_d;
            tx_en_q     <= tx_en_d;
            rx_en_q     <= rx_en_d;
            done_q      <= done_d;
            cmd_rdy_q   <= cmd_rdy_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            rx_count_q  <= rx_count_d;
        end
    end

    assign o_cmd_ready   = cmd_rdy_q;
    assign o_wdata_ready = wdata_rdy;
    assign o_frame       = frame_q;
    assign o_frame_valid = frame_vld_q;
    assign o_tx_en       = tx_en_q;
    assign o_rx_en       = rx_en_q;
    assign o_rx_count    = rx_count_q;
    assign o_done        = done_q;

endmodule

// File: tb/tb_updi_burst_gen.sv
// Bench for updi_burst_gen: two parameter sets, expected frame streams built from the UPDI command sequence.
module tb_updi_burst_gen;

    localparam int AB_A = 2;
    localparam int SB_A = 2;
    localparam int PO_A = 0;
    localparam int FW_A = 10 + SB_A;
    localparam int AB_B = 3;
    localparam int SB_B = 1;
    localparam int PO_B = 1;
    localparam int FW_B = 10 + SB_B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;
    int   tests = 0;
    int   fails = 0;

    logic             cmd_valid_a, cmd_ready_a, cmd_write_a;
    logic [15:0]      cmd_addr_a;
    logic [7:0]       cmd_len_a, wdata_a;
    logic             wdata_valid_a, wdata_ready_a;
    logic [FW_A-1:0]  frame_a;
    logic             frame_valid_a, frame_ready_a, tx_en_a, rx_en_a;
    logic [8:0]       rx_count_a;
    logic             rx_done_a, abort_a, done_a;

    logic             cmd_valid_b, cmd_ready_b, cmd_write_b;
    logic [23:0]      cmd_addr_b;
    logic [7:0]       cmd_len_b, wdata_b;
    logic             wdata_valid_b, wdata_ready_b;
    logic [FW_B-1:0]  frame_b;
    logic             frame_valid_b, frame_ready_b, tx_en_b, rx_en_b;
    logic [8:0]       rx_count_b;
    logic             rx_done_b, abort_b, done_b;

    updi_burst_gen #(.ADDR_BYTES(AB_A), .STOP_BITS(SB_A), .PARITY_ODD(PO_A)) dut_a (
        .i_clk(clk), .i_rstn(rstn),
        .i_cmd_valid(cmd_valid_a), .o_cmd_ready(cmd_ready_a), .i_cmd_write(cmd_write_a),
        .i_cmd_addr(cmd_addr_a), .i_cmd_len(cmd_len_a),
        .i_wdata(wdata_a), .i_wdata_valid(wdata_valid_a), .o_wdata_ready(wdata_ready_a),
        .o_frame(frame_a), .o_frame_valid(frame_valid_a), .i_frame_ready(frame_ready_a),
        .o_tx_en(tx_en_a), .o_rx_en(rx_en_a), .o_rx_count(rx_count_a),
        .i_rx_done(rx_done_a), .i_abort(abort_a), .o_done(done_a)
    );

    updi_burst_gen #(.ADDR_BYTES(AB_B), .STOP_BITS(SB_B), .PARITY_ODD(PO_B)) dut_b (
        .i_clk(clk), .i_rstn(rstn),
        .i_cmd_valid(cmd_valid_b), .o_cmd_ready(cmd_ready_b), .i_cmd_write(cmd_write_b),
        .i_cmd_addr(cmd_addr_b), .i_cmd_len(cmd_len_b),
        .i_wdata(wdata_b), .i_wdata_valid(wdata_valid_b), .o_wdata_ready(wdata_ready_b),
        .o_frame(frame_b), .o_frame_valid(frame_valid_b), .i_frame_ready(frame_ready_b),
        .o_tx_en(tx_en_b), .o_rx_en(rx_en_b), .o_rx_count(rx_count_b),
        .i_rx_done(rx_done_b), .i_abort(abort_b), .o_done(done_b)
    );

    logic [7:0] wq[$];
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW_A-1:0] fa(input logic [7:0] b);
        logic p;
        p = 1'(($countones(b) + PO_A) % 2);
        return {1'b0, b, p, {SB_A{1'b1}}};
    endfunction

    function automatic logic [FW_B-1:0] fb(input logic [7:0] b);
        logic p;
        p = 1'(($countones(b) + PO_B) % 2);
        return {1'b0, b, p, {SB_B{1'b1}}};
    endfunction

    // Expected character stream of one command, straight from the UPDI sequence.
    task automatic build_exp(input bit wr, input logic [23:0] addr, input int ab, input logic [7:0] len);
        exp_q = {};
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h68 + 8'(ab - 1));
        for (int i = 0; i < ab; i++) exp_q.push_back(addr[8*i +: 8]);
        exp_q.push_back(8'h55);
        if (len != 8'd0) begin
            exp_q.push_back(8'hA0);
            exp_q.push_back(len);
            exp_q.push_back(8'h55);
        end
        exp_q.push_back(wr ? 8'h64 : 8'h24);
        if (wr) foreach (wq[i]) exp_q.push_back(wq[i]);
    endtask

    // kill_kind: 0 none, 1 abort (with frame_ready), 2 async reset; fires once kill_after frames were accepted.
    task automatic run_a(input bit wr, input logic [15:0] addr, input logic [7:0] len,
                         input int stall, input int kill_after, input int kill_kind);
        int n, widx, acc_n, cyc, w;
        bit kill, stalled;
        logic [FW_A-1:0] hold;
        n = int'(len) + 1;
        widx = 0; acc_n = 0; cyc = 0; w = 0; kill = 0; stalled = 0; hold = '0;
        wq = {};
        for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
        wq[0] = 8'hA5;
        build_exp(wr, {8'h00, addr}, AB_A, len);
        while (!cmd_ready_a && w < 20) begin step(); w++; end
        chk("cmd_ready_idle", cmd_ready_a, 1);
        cmd_valid_a = 1; cmd_write_a = wr; cmd_addr_a = addr; cmd_len_a = len;
        step();
        cmd_valid_a = 0; cmd_write_a = ~wr; cmd_addr_a = 16'($urandom); cmd_len_a = 8'($urandom);
        chk("sync0_valid", frame_valid_a, 1);
        chk("sync0_tx_en", tx_en_a, 1);
        chk("busy_cmd_ready", cmd_ready_a, 0);
        while (acc_n < exp_q.size() && cyc < 5000) begin
            kill = (kill_kind != 0) && (acc_n == kill_after);
            frame_ready_a = kill || stall == 0 || int'($urandom_range(99)) >= stall;
            wdata_valid_a = (widx < n) && (stall == 0 || int'($urandom_range(99)) >= stall);
            wdata_a = wdata_valid_a ? wq[widx] : 8'($urandom);
            rx_done_a = (stall != 0) && ($urandom_range(9) == 0);
            abort_a = kill && (kill_kind == 1);
            #4;
            if (kill && kill_kind == 2) break;
            if (stalled) begin
                chk("stall_valid", frame_valid_a, 1);
                chk("stall_hold", frame_a, hold);
            end
            chk("no_early_done", done_a, 0);
            if (wdata_ready_a && wdata_valid_a) widx++;
            if (frame_valid_a && frame_ready_a && !kill) begin
                chk("frame", frame_a, fa(exp_q[acc_n]));
                chk("tx_en_busy", tx_en_a, 1);
                acc_n++;
            end
            stalled = frame_valid_a && !frame_ready_a;
            hold = frame_a;
            @(posedge clk);
            #1;
            cyc++;
            if (kill) break;
        end
        frame_ready_a = 1; wdata_valid_a = 0; rx_done_a = 0; abort_a = 0;
        if (kill && kill_kind == 1) begin
            chk("abort_valid", frame_valid_a, 0);
            chk("abort_tx_en", tx_en_a, 0);
            chk("abort_rx_en", rx_en_a, 0);
            chk("abort_done", done_a, 0);
            chk("abort_cmd_ready", cmd_ready_a, 1);
            step();
            chk("abort_no_done", done_a, 0);
        end else if (kill && kill_kind == 2) begin
            rstn = 0;
            #1;
            chk("rst_cmd_ready", cmd_ready_a, 0);
            chk("rst_frame", frame_a, 0);
            chk("rst_valid", frame_valid_a, 0);
            chk("rst_wdata_ready", wdata_ready_a, 0);
            chk("rst_tx_en", tx_en_a, 0);
            chk("rst_rx_en", rx_en_a, 0);
            chk("rst_rx_count", rx_count_a, 0);
            chk("rst_done", done_a, 0);
            step();
            rstn = 1;
            #4;
            chk("rst_release_cmd_ready", cmd_ready_a, 0);
            @(posedge clk);
            #1;
            chk("rst_first_edge_cmd_ready", cmd_ready_a, 1);
        end else if (acc_n < exp_q.size()) begin
            chk("timeout_frames", acc_n, exp_q.size());
        end else begin
            if (stall == 0) chk("no_bubble", cyc, exp_q.size());
            if (wr) begin
                chk("wr_done", done_a, 1);
                chk("wr_tx_en_fall", tx_en_a, 0);
                chk("wr_idle_valid", frame_valid_a, 0);
                chk("wr_done_cmd_ready", cmd_ready_a, 1);
                chk("payload_taken", widx, n);
            end else begin
                chk("rd_rx_en", rx_en_a, 1);
                chk("rd_tx_en", tx_en_a, 0);
                chk("rd_rx_count", rx_count_a, n);
                chk("rd_valid", frame_valid_a, 0);
                chk("rd_wait_done", done_a, 0);
                repeat ($urandom_range(3)) begin
                    step();
                    chk("rd_rx_en_hold", rx_en_a, 1);
                end
                rx_done_a = 1;
                step();
                rx_done_a = 0;
                chk("rd_done", done_a, 1);
                chk("rd_rx_en_fall", rx_en_a, 0);
                chk("rd_done_cmd_ready", cmd_ready_a, 1);
            end
            step();
            chk("done_one_cycle", done_a, 0);
        end
    endtask

    task automatic run_b(input logic [7:0] len);
        int acc_n, cyc;
        acc_n = 0; cyc = 0;
        build_exp(0, 24'h012345, AB_B, len);
        chk("b_cmd_ready", cmd_ready_b, 1);
        cmd_valid_b = 1; cmd_addr_b = 24'h012345; cmd_len_b = len;
        step();
        cmd_valid_b = 0;
        while (acc_n < exp_q.size() && cyc < 100) begin
            #4;
            if (frame_valid_b) begin
                chk("b_frame", frame_b, fb(exp_q[acc_n]));
                acc_n++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("b_frame_count", acc_n, exp_q.size());
        chk("b_rx_en", rx_en_b, 1);
        chk("b_rx_count", rx_count_b, int'(len) + 1);
        chk("b_tx_en", tx_en_b, 0);
        rx_done_b = 1;
        step();
        rx_done_b = 0;
        chk("b_done", done_b, 1);
    endtask

    initial begin
        rstn = 0;
        cmd_valid_a = 0; cmd_write_a = 0; cmd_addr_a = '0; cmd_len_a = '0;
        wdata_a = '0; wdata_valid_a = 0; frame_ready_a = 1; rx_done_a = 0; abort_a = 0;
        cmd_valid_b = 0; cmd_write_b = 0; cmd_addr_b = '0; cmd_len_b = '0;
        wdata_b = '0; wdata_valid_b = 0; frame_ready_b = 1; rx_done_b = 0; abort_b = 0;
        step();
        step();
        chk("reset_cmd_ready", cmd_ready_a, 0);
        chk("reset_frame", frame_a, 0);
        chk("reset_valid", frame_valid_a, 0);
        chk("reset_wdata_ready", wdata_ready_a, 0);
        chk("reset_tx_en", tx_en_a, 0);
        chk("reset_rx_en", rx_en_a, 0);
        chk("reset_rx_count", rx_count_a, 0);
        chk("reset_done", done_a, 0);
        rstn = 1;
        #4;
        chk("release_cmd_ready", cmd_ready_a, 0);
        @(posedge clk);
        #1;
        chk("first_edge_cmd_ready", cmd_ready_a, 1);

        run_a(1, 16'h1234, 8'd0, 0, -1, 0);
        run_a(0, 16'h0F00, 8'd3, 0, -1, 0);
        run_a(1, 16'($urandom), 8'd255, 30, -1, 0);
        for (int k = 0; k < 4; k++)
            run_a(1'($urandom_range(1)), 16'($urandom), 8'($urandom_range(20)),
                  int'($urandom_range(40)), -1, 0);
        run_a(1, 16'h4321, 8'd10, 0, 2, 1);
        run_a(1, 16'($urandom), 8'd20, 30, 12, 1);
        run_a(0, 16'h0F00, 8'd3, 0, -1, 0);
        run_a(1, 16'($urandom), 8'd40, 30, 15, 2);
        run_a(1, 16'($urandom), 8'd5, 20, -1, 0);
        run_b(8'd3);
        run_b(8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
